mc_control: RTL and testbench

- Multicycle sequencer for the MIPS subset RTYPE, LW, SW, BEQ and NOP.
- Replaces the single-shot opcode decoder when the core runs on the shared-memory multicycle datapath.
- Registered FSM steps each instruction through FETCH/DECODE/EXEC/MEM/WB, holding on memory wait states.
- Drives every datapath mux/enable and keeps a retired-instruction counter.

---
 rtl/mc_control.sv | 186 ++++++++++++++++++
 tb/tb_mc_control.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multicycle control sequencer for a MIPS subset
// (RTYPE, LW, SW, BEQ, NOP) on a shared-memory multicycle datapath.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   run               allow fetch of the next instruction
//   opcode            IR[31:26], valid from DECODE onward
//   mem_ready         memory completes the current access this cycle
//   pc_write .. pc_source   datapath mux selects and enables
//   state             current state code (debug)
//   instr_done        pulse on the last cycle of a retired instruction
//   illegal_op        pulse in DECODE on an unsupported opcode
//   instr_count       retired-instruction counter (wraps)
//
// state | meaning
// ------+------------------------------------------------
//  0    | IDLE    waiting for run
//  1    | FETCH   read instruction, PC+4, wait on memory
//  2    | DECODE  branch target into ALUOut, dispatch by opcode
//  3    | MEMADR  compute load/store address
//  4    | MEMRD   load data read, wait on memory
//  5    | MEMWB   write loaded data to rt
//  6    | MEMWR   store data write, wait on memory
//  7    | EXEC    R-type ALU operation
//  8    | RWB     write ALU result to rd
//  9    | BRANCH  compare A/B, conditional PC load
module mc_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       after_done;

  // Every retiring state returns here; run is only looked at on that cycle.
  assign after_done = run ? S_FETCH : S_IDLE;

  always_comb begin
    state_d       = S_IDLE;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state_q)
      S_IDLE: state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC+4 are captured only on the cycle memory delivers.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_NOP: begin
            instr_done = 1'b1;
            state_d    = after_done;
          end
          default: begin
            illegal_op = 1'b1;
            state_d    = after_done;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_IDLE;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = after_done;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? after_done : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_RWB;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = after_done;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_d       = after_done;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (instr_done) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b0;

  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        instr_done, illegal_op;
  logic [15:0] instr_count;

  logic        d4_pc_write, d4_pc_write_cond, d4_iord, d4_mem_read, d4_mem_write, d4_ir_write;
  logic        d4_mem_to_reg, d4_reg_dst, d4_reg_write, d4_alu_src_a;
  logic [1:0]  d4_alu_src_b, d4_alu_op, d4_pc_source;
  logic [3:0]  d4_state;
  logic        d4_instr_done, d4_illegal_op;
  logic [3:0]  d4_instr_count;

  int n_checks = 0;
  int n_err    = 0;
  int exp_count = 0;
  bit in_fetch = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  always #5 clk = ~clk;

  mc_control #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  mc_control #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(d4_pc_write), .pc_write_cond(d4_pc_write_cond), .iord(d4_iord),
    .mem_read(d4_mem_read), .mem_write(d4_mem_write), .ir_write(d4_ir_write),
    .mem_to_reg(d4_mem_to_reg), .reg_dst(d4_reg_dst), .reg_write(d4_reg_write),
    .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op),
    .pc_source(d4_pc_source), .state(d4_state), .instr_done(d4_instr_done),
    .illegal_op(d4_illegal_op), .instr_count(d4_instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Control word order:
  // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [15:0] ctrl_of(input logic [3:0] st, input logic mr);
    case (st)
      4'd1: ctrl_of = {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 3'b000, 1'b0, 2'b01, 2'b00, 2'b00};
      4'd2: ctrl_of = {9'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      4'd3: ctrl_of = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00};
      4'd4: ctrl_of = {2'b00, 1'b1, 1'b1, 5'b00000, 1'b0, 6'b0};
      4'd5: ctrl_of = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0};
      4'd6: ctrl_of = {2'b00, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 6'b0};
      4'd7: ctrl_of = {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
      4'd8: ctrl_of = {7'b0, 1'b1, 1'b1, 1'b0, 6'b0};
      4'd9: ctrl_of = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
      default: ctrl_of = 16'h0;
    endcase
  endfunction

  function automatic logic [15:0] obs_ctrl();
    obs_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  task automatic check_cycle(input logic [3:0] st, input logic mr, input logic done_e,
                             input logic ill_e);
    chk("state", state, st);
    chk("state_w4", d4_state, st);
    chk("ctrl", obs_ctrl(), ctrl_of(st, mr));
    chk("instr_done", instr_done, done_e);
    chk("illegal_op", illegal_op, ill_e);
    chk("rd_wr_excl", mem_read & mem_write, 0);
    chk("regw_mem_excl", reg_write & (mem_read | mem_write), 0);
    chk("count", instr_count, exp_count[15:0]);
    chk("count_w4", d4_instr_count, exp_count[3:0]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sit in IDLE for n cycles with run low, then raise run and enter FETCH.
  task automatic idle_then_start(input int n);
    for (int i = 0; i <= n; i++) begin
      run = (i == n);
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 6'($urandom);
      @(negedge clk);
      check_cycle(4'd0, mem_ready, 1'b0, 1'b0);
      tick();
    end
    in_fetch = 1;
  endtask

  // fw/mw: number of wait cycles in FETCH / memory-data state (-1 = random).
  // run_pat: 0 random, 1 held high, 2 held low.
  task automatic do_instr(input logic [5:0] op, input int fw, input int mw,
                          input int run_pat, output int cycles);
    logic [3:0] path[$];
    logic       illegal, mr, r, waitable;
    logic [3:0] st;
    int         w;
    path.delete();
    path.push_back(4'd1);
    path.push_back(4'd2);
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin path.push_back(4'd7); path.push_back(4'd8); end
      OP_LW:    begin path.push_back(4'd3); path.push_back(4'd4); path.push_back(4'd5); end
      OP_SW:    begin path.push_back(4'd3); path.push_back(4'd6); end
      OP_BEQ:   path.push_back(4'd9);
      OP_NOP:   ;
      default:  illegal = 1'b1;
    endcase
    cycles = 0;
    r = 1'b1;
    for (int idx = 0; idx < path.size(); idx++) begin
      st = path[idx];
      waitable = (st == 4'd1) || (st == 4'd4) || (st == 4'd6);
      w = (st == 4'd1) ? fw : mw;
      for (int k = 0; k < 64; k++) begin
        if (!waitable)  mr = 1'($urandom_range(0, 1));
        else if (w < 0) mr = ($urandom_range(0, 2) != 0) || (k >= 40);
        else            mr = (k >= w);
        r = (run_pat == 0) ? ($urandom_range(0, 4) != 0) : (run_pat == 1);
        mem_ready = mr;
        run = r;
        opcode = (st == 4'd1) ? 6'($urandom) : op;
        @(negedge clk);
        check_cycle(st, mr,
                    (idx == path.size() - 1) && !illegal && (st != 4'd6 || mr),
                    illegal && (st == 4'd2));
        tick();
        cycles++;
        if (!(waitable && !mr)) break;
      end
    end
    if (!illegal) exp_count++;
    in_fetch = r;
  endtask

  task automatic issue(input logic [5:0] op, input int fw, input int mw,
                       input int run_pat, output int cycles);
    if (!in_fetch) idle_then_start($urandom_range(1, 3));
    do_instr(op, fw, mw, run_pat, cycles);
  endtask

  int cyc;
  logic [5:0] rop;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check_cycle(4'd0, mem_ready, 1'b0, 1'b0);
    tick();

    // RTYPE, no waits: 1,2,7,8 then FETCH
    issue(OP_RTYPE, 0, 0, 1, cyc);
    chk("rtype_cycles", cyc, 4);
    chk("rtype_count", instr_count, 1);

    // LW with 3 FETCH waits and 2 MEMRD waits
    issue(OP_LW, 3, 2, 1, cyc);
    chk("lw_cycles", cyc, 10);

    // SW then BEQ back to back
    issue(OP_SW, 0, 0, 1, cyc);
    chk("sw_cycles", cyc, 4);
    issue(OP_BEQ, 0, 0, 1, cyc);
    chk("beq_cycles", cyc, 3);
    chk("count_after_beq", instr_count, 4);

    // NOP then illegal
    issue(OP_NOP, 0, 0, 1, cyc);
    chk("nop_cycles", cyc, 2);
    issue(6'b111111, 0, 0, 1, cyc);
    chk("illegal_cycles", cyc, 2);
    chk("count_after_illegal", instr_count, 5);
    @(negedge clk);
    chk("illegal_returns_fetch", state, 4'd1);

    // Reset in the middle of MEMRD while memory is stalled
    run = 1'b1; opcode = OP_LW; mem_ready = 1'b1;
    tick();  // -> DECODE
    tick();  // -> MEMADR
    tick();  // -> MEMRD
    mem_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_state", state, 4'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run = 1'b0;
    exp_count = 0;
    @(negedge clk);
    check_cycle(4'd0, mem_ready, 1'b0, 1'b0);
    tick();
    in_fetch = 0;

    // 16 NOPs: narrow counter wraps to 0
    for (int i = 0; i < 16; i++) issue(OP_NOP, -1, -1, 1, cyc);
    chk("wrap_w4", d4_instr_count, 0);
    chk("wrap_w16", instr_count, 16);

    // Drop run for the whole LW: it still retires, then IDLE
    issue(OP_LW, 1, 1, 2, cyc);
    chk("lw_norun_cycles", cyc, 7);
    @(negedge clk);
    chk("idle_after_lw", state, 4'd0);
    chk("count_after_lw", instr_count, 17);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0: rop = OP_RTYPE;
        1: rop = OP_LW;
        2: rop = OP_SW;
        3: rop = OP_BEQ;
        4: rop = OP_NOP;
        default: begin
          rop = 6'($urandom);
          if (rop == OP_RTYPE || rop == OP_LW || rop == OP_SW ||
              rop == OP_BEQ || rop == OP_NOP) rop = 6'b111111;
        end
      endcase
      issue(rop, -1, -1, 0, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
